refill_cache_dados: RTL

Miss-handling engine for the 16-line, 32-byte-block data cache. It samples the cache's miss/stall indication and fetches the eight 32-bit words of the missing block from main memory, one word per handshake. It then presents the assembled 256-bit line, index and tag to the cache's line-write port for exactly one cycle. It sits between `cache_dados` and the main-memory read port and is the only writer of cache line state outside reset.

---
 rtl/pkg_cache_dados.sv | 27 ++
 rtl/buffer_bloco.sv | 31 +++
 rtl/refill_cache_dados.sv | 102 ++++++++++
 3 files changed

// File: rtl/pkg_cache_dados.sv
// Shared definitions for the data cache and its refill engine:
// geometry, field widths and the refill FSM state encoding.
package pkg_cache_dados;

  localparam int LINHAS    = 16;
  localparam int PALAVRAS  = 8;
  localparam int INDEX_W   = 4;
  localparam int PALAVRA_W = 3;
  localparam int OFFSET_W  = 5;
  localparam int TAG_W     = 23;
  localparam int BLOCO_W   = 256;
  localparam int BASE_W    = 32 - OFFSET_W;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    BUSCA   = 2'd1,
    ESCRITA = 2'd2,
    ESPERA  = 2'd3
  } estado_t;

  // Word-aligned byte address of word p within the block at base.
  function automatic logic [31:0] endereco_palavra(input logic [BASE_W-1:0] base,
                                                   input logic [PALAVRA_W-1:0] p);
    return {base, p, 2'b00};
  endfunction

endpackage

// File: rtl/buffer_bloco.sv
// Line assembly buffer: eight 32-bit words, written one at a time by
// word select, cleared as a whole, read out as one 256-bit block.
module buffer_bloco
  import pkg_cache_dados::*;
(
  input  logic                 clock,
  input  logic                 limpar,
  input  logic                 we,
  input  logic [PALAVRA_W-1:0] sel,
  input  logic [31:0]          dado,
  output logic [BLOCO_W-1:0]   bloco
);

  logic [31:0] palavras [PALAVRAS];

  // Clear dominates; otherwise store the incoming word in its slot.
  always_ff @(posedge clock) begin
    if (limpar) begin
      for (int k = 0; k < PALAVRAS; k++) palavras[k] <= '0;
    end else if (we) begin
      palavras[sel] <= dado;
    end
  end

  // Word k occupies bits [32k+31:32k] of the block.
  always_comb begin
    bloco = '0;
    for (int k = 0; k < PALAVRAS; k++) bloco[32*k +: 32] = palavras[k];
  end

endmodule

// File: rtl/refill_cache_dados.sv
// Data cache miss-refill engine: latches the missing address, fetches the
// eight words of the block from memory (one per mem_ready handshake) and
// writes the assembled line to the cache for one cycle.
// Build option: REFILL_PALAVRA_CRITICA_EN starts the fetch at the missed
// word and wraps upward; otherwise the fetch starts at word 0.
module refill_cache_dados
  import pkg_cache_dados::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               miss_req,
  input  logic [31:0]        endereco_miss,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_ready,
  input  logic [31:0]        mem_rdata,
  output logic               linha_we,
  output logic [INDEX_W-1:0] linha_index,
  output logic [TAG_W-1:0]   linha_tag,
  output logic [BLOCO_W-1:0] linha_dados,
  output logic               ocupado
);

  estado_t              estado, prox;
  logic [BASE_W-1:0]    end_lat;
  logic [PALAVRA_W-1:0] palavra;
  logic [3:0]           beats;
  logic [PALAVRA_W-1:0] palavra_ini;
  logic                 inicia;
  logic                 aceita;
  logic                 ultimo;

`ifdef REFILL_PALAVRA_CRITICA_EN
  assign palavra_ini = endereco_miss[OFFSET_W-1:2];
`else
  assign palavra_ini = '0;
  // Byte offset only matters for critical-word-first ordering.
  logic unused_offset;
  assign unused_offset = ^endereco_miss[OFFSET_W-1:0];
`endif

  assign inicia = (estado == OCIOSO) && miss_req;
  assign aceita = (estado == BUSCA) && mem_ready;
  assign ultimo = (beats == 4'(PALAVRAS - 1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox;
  end

  // Next-state logic.
  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:  if (miss_req) prox = BUSCA;
      BUSCA:   if (aceita && ultimo) prox = ESCRITA;
      ESCRITA: prox = ESPERA;
      ESPERA:  prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    mem_req  = (estado == BUSCA);
    linha_we = (estado == ESCRITA);
    ocupado  = (estado != OCIOSO);
  end

  // Address latch, word pointer, beat count and registered memory address.
  always_ff @(posedge clock) begin
    if (reset) begin
      end_lat  <= '0;
      palavra  <= '0;
      beats    <= '0;
      mem_addr <= '0;
    end else if (inicia) begin
      end_lat  <= endereco_miss[31:OFFSET_W];
      palavra  <= palavra_ini;
      beats    <= '0;
      mem_addr <= endereco_palavra(endereco_miss[31:OFFSET_W], palavra_ini);
    end else if (aceita) begin
      palavra  <= palavra + 3'd1;
      beats    <= beats + 4'd1;
      mem_addr <= endereco_palavra(end_lat, palavra + 3'd1);
    end
  end

  assign linha_index = end_lat[INDEX_W-1:0];
  assign linha_tag   = end_lat[BASE_W-1:INDEX_W];

  buffer_bloco u_buffer (
    .clock  (clock),
    .limpar (reset || inicia),
    .we     (aceita),
    .sel    (palavra),
    .dado   (mem_rdata),
    .bloco  (linha_dados)
  );

endmodule
